// File: rtl/mem_access_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_pkg : RV32 load/store size codes and request legality check
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_access_ctrl_pkg;

  localparam logic [2:0] L_BYTE   = 3'b000;
  localparam logic [2:0] L_HALF   = 3'b001;
  localparam logic [2:0] L_WORD   = 3'b010;
  localparam logic [2:0] L_BYTE_U = 3'b100;
  localparam logic [2:0] L_HALF_U = 3'b101;
  localparam logic [2:0] S_BYTE   = 3'b000;
  localparam logic [2:0] S_HALF   = 3'b001;
  localparam logic [2:0] S_WORD   = 3'b010;

  // Encoding-level legality only; alignment is judged by mem_lane_align.
  function automatic logic illegal_op(input logic re, input logic we,
                                      input logic [2:0] funct3);
    if (re == we) return 1'b1;
    if (re) return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    return (funct3 > S_WORD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align : lane extraction/extension, store merge, lane mask, alignment
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] raw_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic [3:0]  lane_mask,
  output logic        misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = raw_word[{addr_lo, 3'b000} +: 8];
    w_half = raw_word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      L_BYTE:   load_data = {{24{w_byte[7]}}, w_byte};
      L_HALF:   load_data = {{16{w_half[15]}}, w_half};
      L_BYTE_U: load_data = {24'h0, w_byte};
      L_HALF_U: load_data = {16'h0, w_half};
      default:  load_data = raw_word;
    endcase
  end

  // Size is carried in funct3[1:0]; bit 2 only selects load extension.
  always_comb begin
    store_word = raw_word;
    lane_mask  = 4'b1111;
    misalign   = 1'b0;
    case (funct3[1:0])
      S_BYTE[1:0]: begin
        store_word[{addr_lo, 3'b000} +: 8] = store_data[7:0];
        lane_mask = 4'b0001 << addr_lo;
      end
      S_HALF[1:0]: begin
        store_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
        lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign  = addr_lo[0];
      end
      S_WORD[1:0]: begin
        store_word = store_data;
        misalign   = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl : load/store sequencer for a dual-port data BRAM; optional
//                   MEM_BYTE_WE_EN uses per-lane write enables instead of RMW
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

`ifdef MEM_BYTE_WE_EN
  localparam bit c_subword_rmw = 1'b0;
`else
  localparam bit c_subword_rmw = 1'b1;
`endif

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t              r_state, w_next_state;
  logic [1:0]          r_cnt;
  logic [2:0]          r_funct3;
  logic [ADDR_W+1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [31:0]         r_word;
  logic                r_is_store;
  logic                r_err;

  logic [2:0]          w_funct3;
  logic [1:0]          w_addr_lo;
  logic [31:0]         w_load_data;
  logic [31:0]         w_store_word;
  logic [31:0]         w_wr_data;
  logic [3:0]          w_lane_mask;
  logic                w_misalign;
  logic                w_accept;
  logic                w_req_err;
  logic                w_last_wait;
  logic                w_unused;

  // The aligner looks at the live request while idle (for the alignment
  // check at accept) and at the registered request afterwards.
  assign w_funct3  = (r_state == ST_IDLE) ? req_funct3    : r_funct3;
  assign w_addr_lo = (r_state == ST_IDLE) ? req_addr[1:0] : r_addr[1:0];

  mem_lane_align u_lane_align (
    .funct3     (w_funct3),
    .addr_lo    (w_addr_lo),
    .raw_word   (r_word),
    .store_data (r_wdata),
    .load_data  (w_load_data),
    .store_word (w_store_word),
    .lane_mask  (w_lane_mask),
    .misalign   (w_misalign)
  );

  assign w_accept    = req_valid && (r_state == ST_IDLE);
  assign w_req_err   = illegal_op(req_re, req_we, req_funct3) || w_misalign;
  assign w_last_wait = (r_cnt == 2'(READ_LAT - 1));

`ifdef MEM_BYTE_WE_EN
  always_comb begin
    case (r_funct3[1:0])
      S_BYTE[1:0]: w_wr_data = {4{r_wdata[7:0]}};
      S_HALF[1:0]: w_wr_data = {2{r_wdata[15:0]}};
      default:     w_wr_data = r_wdata;
    endcase
  end
  assign w_unused = ^{req_addr[31:ADDR_W+2], w_store_word};
`else
  assign w_wr_data = w_store_word;
  assign w_unused  = ^req_addr[31:ADDR_W+2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Strobes depend on state alone so reset removes them without a clock.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 4'b0000;
    ram_wdata    = 32'h0;
    resp_valid   = 1'b0;
    resp_rdata   = 32'h0;
    resp_err     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)
            w_next_state = ST_RESP;
          else if (req_re || (c_subword_rmw && req_funct3[1:0] != S_WORD[1:0]))
            w_next_state = ST_RD;
          else
            w_next_state = ST_WR;
        end
      end
      ST_RD: begin
        ram_en       = 1'b1;
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_last_wait) w_next_state = r_is_store ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        ram_we       = c_subword_rmw ? 4'b1111 : w_lane_mask;
        ram_wdata    = w_wr_data;
        w_next_state = ST_RESP;
      end
      ST_RESP: begin
        resp_valid   = 1'b1;
        resp_err     = r_err;
        resp_rdata   = (r_err || r_is_store) ? 32'h0 : w_load_data;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 2'd0;
      r_funct3   <= 3'd0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
      r_word     <= 32'h0;
      r_is_store <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct3   <= req_funct3;
        r_addr     <= req_addr[ADDR_W+1:0];
        r_wdata    <= req_wdata;
        r_is_store <= req_we;
        r_err      <= w_req_err;
      end
      if (r_state == ST_RD)
        r_cnt <= 2'd0;
      else if (r_state == ST_WAIT)
        r_cnt <= r_cnt + 2'd1;
      if (r_state == ST_WAIT && w_last_wait)
        r_word <= ram_rdata;
    end
  end

  assign ram_raddr = r_addr[ADDR_W+1:2];
  assign ram_waddr = r_addr[ADDR_W+1:2];

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl : scoreboard bench with a behavioural 1-cycle BRAM model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_ctrl;

  localparam int ADDR_W  = 10;
  localparam int RL      = 1;
  localparam int TIMEOUT = 30;
`ifdef MEM_BYTE_WE_EN
  localparam bit BWE = 1'b1;
`else
  localparam bit BWE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_re, req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_valid, resp_err;
  logic [31:0]       resp_rdata;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_raddr, ram_waddr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = 32'h0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .READ_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_re(req_re), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_raddr(ram_raddr), .ram_waddr(ram_waddr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (ram_en) ram_rdata <= mem[ram_raddr];
    for (int k = 0; k < 4; k++)
      if (ram_we[k]) mem[ram_waddr][8*k +: 8] <= ram_wdata[8*k +: 8];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        re, we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, rdata;
    logic        err;
    int          resp_cyc, en_cyc, we_cyc;
    logic [3:0]  we_mask;
    logic [31:0] we_data;
  } vec_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int                ob_resp_cyc, ob_en_cyc, ob_en_cnt, ob_we_cyc, ob_we_cnt;
  logic [3:0]        ob_we;
  logic [31:0]       ob_wdata, ob_rdata;
  logic              ob_err;
  logic [ADDR_W-1:0] ob_raddr;

  // Drives one request from idle and records what the DUT does, cycle 0 being
  // the accept cycle.
  task automatic issue(input logic re, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_re = re; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_re = 1'b0; req_we = 1'b0;
    ob_resp_cyc = -1; ob_en_cyc = -1; ob_en_cnt = 0; ob_we_cyc = -1; ob_we_cnt = 0;
    ob_we = 4'h0; ob_wdata = 32'h0; ob_rdata = 32'h0; ob_err = 1'b0; ob_raddr = '0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (ram_en) begin
        if (ob_en_cyc < 0) ob_en_cyc = c;
        ob_en_cnt++;
        ob_raddr = ram_raddr;
      end
      if (ram_we != 4'h0) begin
        if (ob_we_cyc < 0) ob_we_cyc = c;
        ob_we_cnt++;
        ob_we = ram_we;
        ob_wdata = ram_wdata;
      end
      if (resp_valid) begin
        ob_resp_cyc = c;
        ob_rdata = resp_rdata;
        ob_err = resp_err;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_re = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || ram_en !== 1'b0 || ram_we !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_strobes ready=%b resp_valid=%b ram_en=%b ram_we=%b required 1 0 0 0",
               req_ready, resp_valid, ram_en, ram_we);
    end
    n_checks++;
    if (resp_rdata !== 32'h0 || resp_err !== 1'b0 || ram_wdata !== 32'h0 ||
        ram_raddr !== '0 || ram_waddr !== '0) begin
      n_errors++;
      $display("FAIL reset_data rdata=%h err=%b wdata=%h raddr=%h waddr=%h required all 0",
               resp_rdata, resp_err, ram_wdata, ram_raddr, ram_waddr);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_loads();
    vec_t v[7];
    exp_t e;
    v = '{
      '{1'b1, 1'b0, 3'b000, 32'h12, 32'h0, 32'hFFFFFF99, 1'b0, 2+RL, 1, -1, 4'h0, 32'h0},
      '{1'b1, 1'b0, 3'b100, 32'h12, 32'h0, 32'h00000099, 1'b0, 2+RL, 1, -1, 4'h0, 32'h0},
      '{1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 32'h00008899, 1'b0, 2+RL, 1, -1, 4'h0, 32'h0},
      '{1'b1, 1'b0, 3'b001, 32'h10, 32'h0, 32'hFFFFAABB, 1'b0, 2+RL, 1, -1, 4'h0, 32'h0},
      '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h8899AABB, 1'b0, 2+RL, 1, -1, 4'h0, 32'h0},
      '{1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, 2+RL, 1, -1, 4'h0, 32'h0},
      '{1'b1, 1'b0, 3'b010, 32'hABCDF010, 32'h0, 32'h8899AABB, 1'b0, 2+RL, 1, -1, 4'h0, 32'h0}
    };
    foreach (v[i]) begin
      exp_q.push_back('{v[i].rdata, v[i].err, v[i].resp_cyc});
      issue(v[i].re, v[i].we, v[i].f3, v[i].addr, v[i].wdata);
      e = exp_q.pop_front();
      n_checks++;
      if (ob_resp_cyc !== e.cyc || ob_rdata !== e.rdata || ob_err !== e.err) begin
        n_errors++;
        $display("FAIL load[%0d] resp cyc=%0d rdata=%h err=%b required cyc=%0d rdata=%h err=%b",
                 i, ob_resp_cyc, ob_rdata, ob_err, e.cyc, e.rdata, e.err);
      end
      n_checks++;
      if (ob_en_cyc !== v[i].en_cyc || ob_en_cnt !== 1 || ob_raddr !== v[i].addr[ADDR_W+1:2] ||
          ob_we_cnt !== 0) begin
        n_errors++;
        $display("FAIL load_ram[%0d] en_cyc=%0d en_cnt=%0d raddr=%h we_cnt=%0d required %0d 1 %h 0",
                 i, ob_en_cyc, ob_en_cnt, ob_raddr, ob_we_cnt, v[i].en_cyc, v[i].addr[ADDR_W+1:2]);
      end
    end
  endtask

  task automatic test_illegal();
    vec_t v[7];
    exp_t e;
    v = '{
      '{1'b1, 1'b0, 3'b010, 32'h13, 32'h0, 32'h0, 1'b1, 1, -1, -1, 4'h0, 32'h0},
      '{1'b0, 1'b1, 3'b001, 32'h11, 32'h1234, 32'h0, 1'b1, 1, -1, -1, 4'h0, 32'h0},
      '{1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 1, -1, -1, 4'h0, 32'h0},
      '{1'b1, 1'b1, 3'b010, 32'h10, 32'h5, 32'h0, 1'b1, 1, -1, -1, 4'h0, 32'h0},
      '{1'b0, 1'b1, 3'b100, 32'h10, 32'h5, 32'h0, 1'b1, 1, -1, -1, 4'h0, 32'h0},
      '{1'b0, 1'b0, 3'b000, 32'h10, 32'h0, 32'h0, 1'b1, 1, -1, -1, 4'h0, 32'h0},
      '{1'b1, 1'b0, 3'b101, 32'h11, 32'h0, 32'h0, 1'b1, 1, -1, -1, 4'h0, 32'h0}
    };
    foreach (v[i]) begin
      exp_q.push_back('{v[i].rdata, v[i].err, v[i].resp_cyc});
      issue(v[i].re, v[i].we, v[i].f3, v[i].addr, v[i].wdata);
      e = exp_q.pop_front();
      n_checks++;
      if (ob_resp_cyc !== e.cyc || ob_rdata !== e.rdata || ob_err !== e.err) begin
        n_errors++;
        $display("FAIL illegal[%0d] resp cyc=%0d rdata=%h err=%b required cyc=%0d rdata=%h err=%b",
                 i, ob_resp_cyc, ob_rdata, ob_err, e.cyc, e.rdata, e.err);
      end
      n_checks++;
      if (ob_en_cnt !== 0 || ob_we_cnt !== 0) begin
        n_errors++;
        $display("FAIL illegal_ram[%0d] en_cnt=%0d we_cnt=%0d required 0 0", i, ob_en_cnt, ob_we_cnt);
      end
    end
  endtask

  task automatic test_stores();
    vec_t v[6];
    exp_t e;
    v = '{
      '{1'b0, 1'b1, 3'b000, 32'h11, 32'h12345655, 32'h0, 1'b0, BWE ? 2 : 3+RL, BWE ? -1 : 1,
        BWE ? 1 : 2+RL, BWE ? 4'b0010 : 4'b1111, BWE ? 32'h55555555 : 32'h889955BB},
      '{1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 32'h889955BB, 1'b0, 2+RL, 1, -1, 4'h0, 32'h0},
      '{1'b0, 1'b1, 3'b001, 32'h16, 32'hABCDCAFE, 32'h0, 1'b0, BWE ? 2 : 3+RL, BWE ? -1 : 1,
        BWE ? 1 : 2+RL, BWE ? 4'b1100 : 4'b1111, BWE ? 32'hCAFECAFE : 32'hCAFE3344},
      '{1'b1, 1'b0, 3'b010, 32'h14, 32'h0, 32'hCAFE3344, 1'b0, 2+RL, 1, -1, 4'h0, 32'h0},
      '{1'b0, 1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, -1, 1, 4'b1111, 32'hDEADBEEF},
      '{1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2+RL, 1, -1, 4'h0, 32'h0}
    };
    foreach (v[i]) begin
      exp_q.push_back('{v[i].rdata, v[i].err, v[i].resp_cyc});
      issue(v[i].re, v[i].we, v[i].f3, v[i].addr, v[i].wdata);
      e = exp_q.pop_front();
      n_checks++;
      if (ob_resp_cyc !== e.cyc || ob_rdata !== e.rdata || ob_err !== e.err) begin
        n_errors++;
        $display("FAIL store_seq[%0d] resp cyc=%0d rdata=%h err=%b required cyc=%0d rdata=%h err=%b",
                 i, ob_resp_cyc, ob_rdata, ob_err, e.cyc, e.rdata, e.err);
      end
      n_checks++;
      if (ob_en_cyc !== v[i].en_cyc || ob_we_cyc !== v[i].we_cyc || ob_we !== v[i].we_mask ||
          ob_wdata !== v[i].we_data || ob_we_cnt > 1) begin
        n_errors++;
        $display("FAIL store_ram[%0d] en_cyc=%0d we_cyc=%0d we=%b wdata=%h required %0d %0d %b %h",
                 i, ob_en_cyc, ob_we_cyc, ob_we, ob_wdata,
                 v[i].en_cyc, v[i].we_cyc, v[i].we_mask, v[i].we_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    int   we_seen   = 0;
    int   abort_cyc = BWE ? 1 : 2;
    exp_t e;
    @(negedge clk);
    req_re = 1'b0; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h12;
    req_wdata = 32'h00007777; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    for (int c = 1; c < abort_cyc; c++) begin
      if (ram_we != 4'h0) we_seen++;
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ram_en !== 1'b0 || ram_we !== 4'h0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_async en=%b we=%b resp_valid=%b ready=%b required 0 0 0 1",
               ram_en, ram_we, resp_valid, req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (ram_we != 4'h0) we_seen++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || we_seen !== 0) begin
      n_errors++;
      $display("FAIL abort_release ready=%b we_cycles=%0d required 1 0", req_ready, we_seen);
    end
    exp_q.push_back('{32'h889955BB, 1'b0, 2+RL});
    issue(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    e = exp_q.pop_front();
    n_checks++;
    if (ob_resp_cyc !== e.cyc || ob_rdata !== e.rdata || ob_err !== e.err) begin
      n_errors++;
      $display("FAIL abort_readback cyc=%0d rdata=%h err=%b required cyc=%0d rdata=%h err=%b",
               ob_resp_cyc, ob_rdata, ob_err, e.cyc, e.rdata, e.err);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n_resp = 0;
    int   acc2 = -1;
    int   ready_busy = 0;
    exp_q.push_back('{32'h889955BB, 1'b0, 2+RL});
    exp_q.push_back('{32'h0000CAFE, 1'b0, 5+2*RL});
    @(negedge clk);
    req_re = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_funct3 = 3'b101; req_addr = 32'h16;
    for (int c = 1; c <= TIMEOUT && n_resp < 2; c++) begin
      if (resp_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL b2b_extra resp at cycle %0d with no request outstanding", c);
        end else begin
          e = exp_q.pop_front();
          if (c !== e.cyc || resp_rdata !== e.rdata || resp_err !== e.err) begin
            n_errors++;
            $display("FAIL b2b_resp%0d cyc=%0d rdata=%h err=%b required cyc=%0d rdata=%h err=%b",
                     n_resp, c, resp_rdata, resp_err, e.cyc, e.rdata, e.err);
          end
        end
        n_resp++;
      end
      if (req_ready && (n_resp == 0 || (n_resp == 1 && acc2 >= 0))) ready_busy++;
      if (req_ready && req_valid && acc2 < 0) acc2 = c;
      @(negedge clk);
      if (acc2 >= 0) begin
        req_valid = 1'b0; req_re = 1'b0;
      end
    end
    req_valid = 1'b0; req_re = 1'b0;
    n_checks++;
    if (n_resp !== 2 || acc2 !== 3+RL) begin
      n_errors++;
      $display("FAIL b2b_accept responses=%0d second_accept_cyc=%0d required 2 %0d",
               n_resp, acc2, 3+RL);
    end
    n_checks++;
    if (ready_busy !== 0) begin
      n_errors++;
      $display("FAIL b2b_ready_busy ready high in %0d busy cycles required 0", ready_busy);
    end
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    mem[5] = 32'h11223344;
    test_reset();
    test_loads();
    test_illegal();
    test_stores();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer between the core's load/store stage and the data block RAM. The RAM is dual-port, with a synchronous read of READ_LAT cycles and a single 32-bit write enable.
- Accepts one load or store per handshake and checks alignment.
- Loads: extracts the byte or half lane and sign- or zero-extends it.
- Sub-word stores: performed as read-modify-write, because the RAM has no byte enables.
- Returns a single-cycle response with data or an error flag.

Parameters:
ADDR_W, 10, RAM word-address width (byte address bits [ADDR_W+1:2])
READ_LAT, 1, RAM read latency in cycles, legal 1..3

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_re  in  1  load request
req_we  in  1  store request
req_funct3  in  3  access size/sign, RV32 load/store encoding
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned or illegal request
ram_en  out  1  RAM read enable
ram_we  out  4  RAM write enable; all-ones or zero unless MEM_BYTE_WE_EN
ram_raddr  out  ADDR_W  read word address
ram_waddr  out  ADDR_W  write word address
ram_wdata  out  32  write data
ram_rdata  in  32  read data, valid READ_LAT cycles after ram_en

Behaviour:
- Reset: state IDLE. All outputs are 0 except req_ready. Assertion clears state asynchronously.
- RAM strobes are decoded from state only. Asserting reset therefore drops ram_en/ram_we immediately.
- An in-flight operation is abandoned. Memory is untouched, because the write happens only in the single WR cycle.
- States:
  - IDLE: req_ready=1. Accept on req_valid&&req_ready and register the request.
  - RD: ram_en=1 for one cycle.
  - WAIT: counter runs READ_LAT cycles. ram_rdata is captured at the end of the last WAIT cycle.
  - WR: ram_we asserted for one cycle.
  - RESP: resp_valid=1 for one cycle, then IDLE.
- req_ready=0 outside IDLE, so at most one request is outstanding.
- Illegal requests (go IDLE -> RESP with resp_err=1 and no RAM activity):
  - req_re==req_we;
  - load funct3 in {011,110,111};
  - store funct3 >= 011;
  - misaligned address: half with addr[0]=1, or word with addr[1:0]!=0.
- Latency, with accept in cycle 0:
  - load: RD in cycle 1, resp in cycle 2+READ_LAT;
  - word store: WR in cycle 1, resp in cycle 2;
  - sub-word store: RD in cycle 1, WR in cycle 2+READ_LAT, resp in cycle 3+READ_LAT.
- Lane rules:
  - byte lane = addr[1:0] (bits 8*k+7:8*k);
  - half lane = addr[1] (bits 16*h+15:16*h).
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend.
- Store merge: replace the selected lane in the captured word with req_wdata[7:0] or [15:0]; the other bytes are preserved.
- ram_raddr = ram_waddr = registered addr[ADDR_W+1:2]. Upper address bits are ignored.
- resp_rdata and resp_err are valid only while resp_valid is high, and are 0 otherwise.

Optional Feature:
MEM_BYTE_WE_EN.
- Defined: sub-word stores skip RD/WAIT and go directly to WR.
  - ram_we is a one-hot or two-hot lane mask.
  - ram_wdata has the store data replicated into every lane.
  - Latency is identical to a word store.
- Undefined: RMW sequence as above; ram_we is 4'b1111 in WR.

Decomposition:
- Shared defines header (existing): L_BYTE=000, L_HALF=001, L_WORD=010, L_BYTE_U=100, L_HALF_U=101, S_BYTE=000, S_HALF=001, S_WORD=010.
- State encodings stay local to mem_access_ctrl.
- One combinational sub-module, mem_lane_align:
  - inputs: funct3, addr[1:0], raw word, store data;
  - outputs: extended load data, merged store word, lane mask, misalign flag.

Test Plan (word 0x10 preloaded with 0x8899AABB, READ_LAT=1):
- LB 0x12 -> resp_valid in cycle 3, resp_rdata=0xFFFFFF99, err=0; LBU 0x12 -> 0x00000099.
- LHU 0x12 -> 0x00008899; LH 0x10 -> 0xFFFFAABB; LW 0x10 -> 0x8899AABB.
- SB 0x11, wdata 0x12345655 -> ram_en in cycle 1, ram_we=1111 with wdata 0x889955BB in cycle 3, resp in cycle 4. A following LW 0x10 returns 0x889955BB. With MEM_BYTE_WE_EN: ram_we=0010 in cycle 1, resp in cycle 2.
- LW 0x13, SH 0x11, funct3=011 load, re=we=1 -> each gives resp_err=1 in cycle 1, ram_en=ram_we=0 throughout.
- SH 0x12 with reset asserted during WAIT -> ram_we never asserts, word unchanged, req_ready=1 right after reset release.
- Back-to-back requests with req_valid held -> req_ready low until RESP retires; second request accepted in the cycle after resp_valid.
